ifft_frame_feeder: RTL and testbench
====================================

# ifft_frame_feeder

Frame buffer between the spectral resampler and the IFFT. It accepts the resampler's non-backpressured 2^WIDTH-bin output stream, stores whole frames in a two-bank (ping-pong) buffer, and replays each frame in natural bin order to the IFFT over an AXI-Stream master with full `tready` backpressure. `in_ready` tells the resampler when a bank is free, so it can start its next frame.

## Interface
- `WIDTH`, 11: bin-index width; frame length N = 2^WIDTH bins.
- `DATA_W`, 80: complex bin width, {re[79:40], im[39:0]}.
- `clk`, in, 1: clock.
- `rst`, in, 1: reset, synchronous, active-high.
- `in_data`, in, DATA_W: resampled bin value.
- `in_valid`, in, 1: `in_data` / `in_k` valid. There is no backpressure: the source streams the whole frame once started.
- `in_last`, in, 1: final bin of the frame, qualified by `in_valid`.
- `in_k`, in, WIDTH+1: bin index. Bits [WIDTH-1:0] are the write address; the MSB is ignored.
- `in_ready`, out, 1: registered; high when at least one bank is EMPTY.
- `m_tdata`, out, DATA_W: bin to the IFFT.
- `m_tuser`, out, WIDTH: bin index of `m_tdata`.
- `m_tvalid`, out, 1: AXI-S valid.
- `m_tlast`, out, 1: high on bin N-1.
- `m_tready`, in, 1: AXI-S ready.
- `err_overrun`, out, 1: one-cycle pulse; frame discarded because no bank was free.
- `err_len`, out, 1: one-cycle pulse; frame discarded because its write count ≠ N.

## Operation
- Two banks, each N×DATA_W simple dual-port RAM with 1-cycle read latency. Each bank has a state EMPTY, FILLING, or FULL.
- **Write FSM, W_IDLE:**
  - On the first `in_valid` with a bank EMPTY: pick the lower-numbered EMPTY bank, mark it FILLING, write the beat, set wcount=1, go to W_FILL.
  - If no bank is EMPTY: go to W_DROP.
- **Write FSM, W_FILL:**
  - Each `in_valid` writes `in_data` at `in_k[WIDTH-1:0]` and increments wcount (WIDTH+1 bits, saturating at 2^(WIDTH+1)-1).
  - On `in_last`: if the final wcount = N, the bank becomes FULL and is appended to the 2-deep read-order queue. Otherwise the bank returns to EMPTY and `err_len` pulses. Either way, go to W_IDLE.
- **Write FSM, W_DROP:** ignore all beats. On `in_last`, pulse `err_overrun` and go to W_IDLE.
- A single-beat frame (`in_valid` && `in_last` in W_IDLE) follows the same rules: write, count=1, then `err_len` unless N=1.
- Out-of-order `in_k` is legal; the data lands at its address. Duplicate indices overwrite and still count.
- **Read FSM:**
  - R_IDLE: when the queue head bank is FULL, set raddr=0 and go to R_STREAM.
  - R_STREAM: RAM read issued ahead into a 2-entry output skid buffer. raddr advances whenever the skid buffer has space, so throughput is 1 beat/cycle while `m_tready`=1.
  - `m_tuser` = address of the presented beat. `m_tlast` = (`m_tuser` == N-1).
  - On the `m_tlast` handshake: the bank goes to EMPTY, the queue pops, go to R_IDLE. If the other bank is already FULL, go straight to R_STREAM instead.
- **Simultaneous events:** a bank freed by the read side is visible to `in_ready` and to write allocation from the next cycle. A bank may not be both FILLING and read.
- **Reset:** banks go to EMPTY, the queue is cleared, both FSMs go idle, and partial frames are lost. RAM contents are not cleared.

## Timing
- Values during reset: `in_ready`=0, `m_tvalid`=0, `m_tlast`=0, `m_tdata`=0, `m_tuser`=0, `err_*`=0.
- `in_ready`=1 in the first cycle after `rst` deasserts.
- `in_ready` falls the cycle after the second bank leaves EMPTY. It rises the cycle after a bank returns to EMPTY.
- Latency: `in_last` accepted at cycle t with the read side idle → `m_tvalid`=1 with bin 0 at t+3.
- AXI-S rules:
  - Once `m_tvalid` is asserted, `m_tvalid`, `m_tdata`, `m_tuser` and `m_tlast` hold until the handshake.
  - `m_tvalid` never depends combinationally on `m_tready`.
- Back-to-back: with `m_tready`=1, consecutive frames leave with no bubble if the next bank is FULL before the current `m_tlast` handshake.
- `err_*` pulses occur the cycle after the offending `in_last`.

## Configuration
- `FEEDER_DROP_CNT_EN` defined:
  - Adds output `drop_cnt` [15:0]: a saturating count of `err_overrun` plus `err_len` events.
  - Reset to 0. A simultaneous pair of events counts 2.
- `FEEDER_DROP_CNT_EN` undefined: the port and counter are absent. The pulses are unchanged.

## Test plan
- Single frame, N=2048, in_k 0..2047, `m_tready`=1:
  - `m_tvalid` at in_last+3.
  - 2048 beats, data matches, `m_tuser` 0..2047.
  - `m_tlast` only on beat 2047.
  - `in_ready` stays 1.
- Three frames back-to-back, `m_tready` held 0:
  - `in_ready` drops after frame 2 starts.
  - Frame 3 is discarded with one `err_overrun` pulse (`drop_cnt`=1 if enabled).
  - On release, frames 1 and 2 emerge in order.
- Random `m_tready` (50% duty) over 4 frames:
  - No beat lost or duplicated.
  - Outputs stable while `m_tvalid`=1 and `m_tready`=0.
- Frame of 2047 beats ending with in_last:
  - `err_len` pulses.
  - No output frame.
  - The bank returns to EMPTY and `in_ready` stays 1.
- Reverse-order in_k 2047..0:
  - Output is still in natural order, with each `m_tdata` equal to the value written at that index.
- `rst` asserted mid-stream (write beat 1000, read beat 500):
  - Next cycle all outputs are at reset values.
  - After release, a fresh frame passes cleanly.

Source files
------------

// File: rtl/ifft_frame_feeder.sv
`default_nettype none
// ============================================================================
// Module   : ifft_frame_feeder
// Brief    : Ping-pong frame buffer between the spectral resampler and the
//            IFFT; replays whole frames in natural bin order over AXI-Stream.
//            Define FEEDER_DROP_CNT_EN to add the saturating drop_cnt output.
// Revision : 1.0 - initial release
// ============================================================================
module ifft_frame_feeder #(
    parameter int WIDTH  = 11,
    parameter int DATA_W = 80
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    input  logic              in_last,
    input  logic [WIDTH:0]    in_k,
    output logic              in_ready,
    output logic [DATA_W-1:0] m_tdata,
    output logic [WIDTH-1:0]  m_tuser,
    output logic              m_tvalid,
    output logic              m_tlast,
    input  logic              m_tready,
`ifdef FEEDER_DROP_CNT_EN
    output logic [15:0]       drop_cnt,
`endif
    output logic              err_overrun,
    output logic              err_len
);

    localparam int             c_depth     = 1 << WIDTH;
    localparam logic [WIDTH:0] c_frame_len = {1'b1, {WIDTH{1'b0}}};
    localparam logic [WIDTH:0] c_one       = {{WIDTH{1'b0}}, 1'b1};
    localparam logic [WIDTH:0] c_cnt_max   = {(WIDTH+1){1'b1}};
    localparam logic [WIDTH-1:0] c_last_addr = {WIDTH{1'b1}};

    typedef enum logic [1:0] {BANK_EMPTY = 2'd0, BANK_FILLING = 2'd1, BANK_FULL = 2'd2} bank_state_t;
    typedef enum logic [1:0] {W_IDLE = 2'd0, W_FILL = 2'd1, W_DROP = 2'd2} wr_state_t;
    typedef enum logic [0:0] {R_IDLE = 1'b0, R_STREAM = 1'b1} rd_state_t;

    // Bank bookkeeping and the 2-deep read-order queue (second entry is always ~head)
    bank_state_t     r_bank [2];
    bank_state_t     w_bank_nxt [2];
    logic            r_qhead, w_qhead_nxt;
    logic [1:0]      r_qcnt, w_qcnt_nxt, w_qcnt_after_pop;
    logic [1:0]      r_iss_pend;

    // Write side
    wr_state_t       r_wr_state, w_wr_state_nxt;
    logic            r_wr_bank, w_wr_bank_nxt;
    logic [WIDTH:0]  r_wcount, w_wcount_nxt, w_cnt_inc;
    logic            w_any_empty, w_free_bank;
    logic            w_mem_we, w_mem_wbank;
    logic            w_fill_start, w_fill_ok, w_fill_bad;
    logic            w_err_len_nxt, w_err_ovr_nxt;
    logic            r_err_len, r_err_overrun, r_in_ready;
    logic            w_unused_k_msb;

    // Read side
    rd_state_t       r_rd_state, w_rd_state_nxt;
    logic            r_rd_bank, w_rd_bank_nxt;
    logic [WIDTH-1:0] r_raddr, w_raddr_nxt;
    logic            w_rd_pending, w_have_work, w_issue, w_iss_last, w_iss_bank;
    logic [WIDTH-1:0] w_iss_addr;
    logic [2:0]      w_fcnt_sum;
    logic            w_space, w_pop, w_last_hs;
    logic            r_infl, r_infl_bank;
    logic [WIDTH-1:0] r_infl_addr;
    logic [DATA_W-1:0] w_rdata;

    // Output skid FIFO
    logic [DATA_W-1:0] r_fifo_data [2];
    logic [WIDTH-1:0]  r_fifo_user [2];
    logic              r_fwptr, r_frptr;
    logic [1:0]        r_fcnt;

    assign w_unused_k_msb = in_k[WIDTH];
    assign w_any_empty    = (r_bank[0] == BANK_EMPTY) || (r_bank[1] == BANK_EMPTY);
    assign w_free_bank    = (r_bank[0] == BANK_EMPTY) ? 1'b0 : 1'b1;
    assign w_cnt_inc      = (r_wcount == c_cnt_max) ? r_wcount : r_wcount + 1'b1;

    always_comb begin
        w_wr_state_nxt = r_wr_state;
        w_wr_bank_nxt  = r_wr_bank;
        w_wcount_nxt   = r_wcount;
        w_mem_we       = 1'b0;
        w_mem_wbank    = r_wr_bank;
        w_fill_start   = 1'b0;
        w_fill_ok      = 1'b0;
        w_fill_bad     = 1'b0;
        w_err_len_nxt  = 1'b0;
        w_err_ovr_nxt  = 1'b0;
        case (r_wr_state)
            W_IDLE: begin
                if (in_valid) begin
                    if (w_any_empty) begin
                        w_mem_we      = 1'b1;
                        w_mem_wbank   = w_free_bank;
                        w_wr_bank_nxt = w_free_bank;
                        w_wcount_nxt  = c_one;
                        if (in_last) begin
                            w_fill_ok     = (c_one == c_frame_len);
                            w_fill_bad    = (c_one != c_frame_len);
                            w_err_len_nxt = (c_one != c_frame_len);
                        end else begin
                            w_fill_start   = 1'b1;
                            w_wr_state_nxt = W_FILL;
                        end
                    end else if (in_last) begin
                        w_err_ovr_nxt = 1'b1;
                    end else begin
                        w_wr_state_nxt = W_DROP;
                    end
                end
            end
            W_FILL: begin
                if (in_valid) begin
                    w_mem_we     = 1'b1;
                    w_wcount_nxt = w_cnt_inc;
                    if (in_last) begin
                        w_fill_ok      = (w_cnt_inc == c_frame_len);
                        w_fill_bad     = (w_cnt_inc != c_frame_len);
                        w_err_len_nxt  = (w_cnt_inc != c_frame_len);
                        w_wr_state_nxt = W_IDLE;
                    end
                end
            end
            W_DROP: begin
                if (in_valid && in_last) begin
                    w_err_ovr_nxt  = 1'b1;
                    w_wr_state_nxt = W_IDLE;
                end
            end
            default: w_wr_state_nxt = W_IDLE;
        endcase
    end

    // Write and read sides only ever touch different banks in the same cycle
    always_comb begin
        w_bank_nxt = r_bank;
        if (w_fill_start) w_bank_nxt[w_mem_wbank] = BANK_FILLING;
        if (w_fill_ok)    w_bank_nxt[w_mem_wbank] = BANK_FULL;
        if (w_fill_bad)   w_bank_nxt[w_mem_wbank] = BANK_EMPTY;
        if (w_last_hs)    w_bank_nxt[r_qhead]     = BANK_EMPTY;

        w_qcnt_after_pop = r_qcnt - 2'(w_last_hs);
        w_qhead_nxt      = w_last_hs ? ~r_qhead : r_qhead;
        if (w_fill_ok && (w_qcnt_after_pop == 2'd0)) w_qhead_nxt = w_mem_wbank;
        w_qcnt_nxt = w_qcnt_after_pop + 2'(w_fill_ok);
    end

    // Reads run ahead of the FIFO; a frame is "issued" once its last address is read
    assign w_rd_pending = (r_qcnt > r_iss_pend);
    assign w_iss_bank   = (r_rd_state == R_STREAM) ? r_rd_bank : (r_qhead ^ r_iss_pend[0]);
    assign w_iss_addr   = (r_rd_state == R_STREAM) ? r_raddr : {WIDTH{1'b0}};
    assign w_have_work  = (r_rd_state == R_STREAM) || w_rd_pending;
    assign w_pop        = m_tvalid && m_tready;
    assign w_fcnt_sum   = 3'(r_fcnt) + 3'(r_infl) - 3'(w_pop);
    assign w_space      = (w_fcnt_sum < 3'd2);
    assign w_issue      = w_have_work && w_space;
    assign w_iss_last   = w_issue && (w_iss_addr == c_last_addr);
    assign w_last_hs    = w_pop && m_tlast;

    always_comb begin
        w_rd_state_nxt = r_rd_state;
        w_rd_bank_nxt  = r_rd_bank;
        w_raddr_nxt    = r_raddr;
        if (w_issue) begin
            if (w_iss_addr == c_last_addr) begin
                w_rd_state_nxt = R_IDLE;
            end else begin
                w_rd_state_nxt = R_STREAM;
                w_rd_bank_nxt  = w_iss_bank;
                w_raddr_nxt    = w_iss_addr + 1'b1;
            end
        end
    end

    generate
        for (genvar b = 0; b < 2; b++) begin : g_bank
            logic [DATA_W-1:0] r_mem [c_depth];
            logic [DATA_W-1:0] r_rdata;
            always_ff @(posedge clk) begin
                if (w_mem_we && (w_mem_wbank == 1'(b))) r_mem[in_k[WIDTH-1:0]] <= in_data;
                if (w_issue && (w_iss_bank == 1'(b)))   r_rdata <= r_mem[w_iss_addr];
            end
        end
    endgenerate

    assign w_rdata = r_infl_bank ? g_bank[1].r_rdata : g_bank[0].r_rdata;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_bank[0]     <= BANK_EMPTY;
            r_bank[1]     <= BANK_EMPTY;
            r_qhead       <= 1'b0;
            r_qcnt        <= 2'd0;
            r_iss_pend    <= 2'd0;
            r_wr_state    <= W_IDLE;
            r_wr_bank     <= 1'b0;
            r_wcount      <= '0;
            r_err_len     <= 1'b0;
            r_err_overrun <= 1'b0;
            r_in_ready    <= 1'b0;
            r_rd_state    <= R_IDLE;
            r_rd_bank     <= 1'b0;
            r_raddr       <= '0;
            r_infl        <= 1'b0;
            r_infl_bank   <= 1'b0;
            r_infl_addr   <= '0;
        end else begin
            r_bank        <= w_bank_nxt;
            r_qhead       <= w_qhead_nxt;
            r_qcnt        <= w_qcnt_nxt;
            r_iss_pend    <= r_iss_pend + 2'(w_iss_last) - 2'(w_last_hs);
            r_wr_state    <= w_wr_state_nxt;
            r_wr_bank     <= w_wr_bank_nxt;
            r_wcount      <= w_wcount_nxt;
            r_err_len     <= w_err_len_nxt;
            r_err_overrun <= w_err_ovr_nxt;
            r_in_ready    <= w_any_empty;
            r_rd_state    <= w_rd_state_nxt;
            r_rd_bank     <= w_rd_bank_nxt;
            r_raddr       <= w_raddr_nxt;
            r_infl        <= w_issue;
            r_infl_bank   <= w_iss_bank;
            r_infl_addr   <= w_iss_addr;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_fifo_data[0] <= '0;
            r_fifo_data[1] <= '0;
            r_fifo_user[0] <= '0;
            r_fifo_user[1] <= '0;
            r_fwptr        <= 1'b0;
            r_frptr        <= 1'b0;
            r_fcnt         <= 2'd0;
        end else begin
            if (r_infl) begin
                r_fifo_data[r_fwptr] <= w_rdata;
                r_fifo_user[r_fwptr] <= r_infl_addr;
                r_fwptr              <= ~r_fwptr;
            end
            if (w_pop) r_frptr <= ~r_frptr;
            r_fcnt <= r_fcnt + 2'(r_infl) - 2'(w_pop);
        end
    end

    assign m_tvalid    = (r_fcnt != 2'd0);
    assign m_tdata     = r_fifo_data[r_frptr];
    assign m_tuser     = r_fifo_user[r_frptr];
    assign m_tlast     = m_tvalid && (m_tuser == c_last_addr);
    assign in_ready    = r_in_ready;
    assign err_len     = r_err_len;
    assign err_overrun = r_err_overrun;

`ifdef FEEDER_DROP_CNT_EN
    logic [15:0] r_drop_cnt;
    logic [16:0] w_drop_sum;

    assign w_drop_sum = {1'b0, r_drop_cnt} + 17'(r_err_len) + 17'(r_err_overrun);

    always_ff @(posedge clk) begin
        if (rst) r_drop_cnt <= 16'd0;
        else     r_drop_cnt <= w_drop_sum[16] ? 16'hFFFF : w_drop_sum[15:0];
    end

    assign drop_cnt = r_drop_cnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_ifft_frame_feeder.sv
`default_nettype none
// ============================================================================
// Module   : tb_ifft_frame_feeder
// Brief    : Scoreboard bench for ifft_frame_feeder with a frame-level model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ifft_frame_feeder;

    localparam int WIDTH  = 11;
    localparam int DATA_W = 80;
    localparam int N      = 1 << WIDTH;

    logic              clk = 1'b0;
    logic              rst;
    logic [DATA_W-1:0] in_data;
    logic              in_valid, in_last, in_ready;
    logic [WIDTH:0]    in_k;
    logic [DATA_W-1:0] m_tdata;
    logic [WIDTH-1:0]  m_tuser;
    logic              m_tvalid, m_tlast, m_tready;
    logic              err_overrun, err_len;
`ifdef FEEDER_DROP_CNT_EN
    logic [15:0]       drop_cnt;
`endif

    always #5 clk = ~clk;

    ifft_frame_feeder #(.WIDTH(WIDTH), .DATA_W(DATA_W)) dut (
        .clk(clk), .rst(rst),
        .in_data(in_data), .in_valid(in_valid), .in_last(in_last), .in_k(in_k),
        .in_ready(in_ready),
        .m_tdata(m_tdata), .m_tuser(m_tuser), .m_tvalid(m_tvalid),
        .m_tlast(m_tlast), .m_tready(m_tready),
`ifdef FEEDER_DROP_CNT_EN
        .drop_cnt(drop_cnt),
`endif
        .err_overrun(err_overrun), .err_len(err_len)
    );

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic [WIDTH-1:0]  user;
        logic              last;
    } beat_t;

    beat_t exp_q [$];
    int    n_checks = 0, n_pass = 0;
    int    pending = 0;           // complete frames accepted but not yet fully output
    int    exp_len = 0, exp_ovr = 0, obs_len = 0, obs_ovr = 0, exp_drops = 0;
    bit    rand_ready = 1'b0;
    logic  fixed_ready = 1'b1;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s: actual %0h required %0h", name, act, req);
    endtask

    task automatic fail_now(input string name);
        n_checks++;
        $display("FAIL %s: actual timeout required completion", name);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_in_ready"}, in_ready, 0);
        check({tag, "_tvalid"}, m_tvalid, 0);
        check({tag, "_tlast"}, m_tlast, 0);
        check({tag, "_tdata"}, m_tdata, 0);
        check({tag, "_tuser"}, m_tuser, 0);
        check({tag, "_errs"}, {err_len, err_overrun}, 0);
`ifdef FEEDER_DROP_CNT_EN
        check({tag, "_drop_cnt"}, drop_cnt, 0);
`endif
    endtask

    // Ready driver: fixed level or 50% random, updated just after each edge
    initial begin
        m_tready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            m_tready = rand_ready ? 1'($urandom_range(0, 1)) : fixed_ready;
        end
    end

    // Monitor: pops the scoreboard on every handshake and checks AXI-S holding
    initial begin
        beat_t e, prev;
        logic  prev_stall;
        prev_stall = 1'b0;
        prev = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_stall = 1'b0;
            end else begin
                if (err_len) obs_len++;
                if (err_overrun) obs_ovr++;
                if (prev_stall) begin
                    check("hold_tvalid", m_tvalid, 1);
                    check("hold_beat", {m_tdata, m_tuser, m_tlast}, prev);
                end
                if (m_tvalid && m_tready) begin
                    if (exp_q.size() == 0) begin
                        n_checks++;
                        $display("FAIL unexpected_beat: actual tuser %0d required no beat", m_tuser);
                    end else begin
                        e = exp_q.pop_front();
                        check("beat_data", m_tdata, e.data);
                        check("beat_tuser", m_tuser, e.user);
                        check("beat_tlast", m_tlast, e.last);
                        if (e.last) pending--;
                    end
                end
                prev_stall = m_tvalid && !m_tready;
                prev = {m_tdata, m_tuser, m_tlast};
            end
        end
    end

    task automatic set_ready(input bit rnd, input logic val);
        rand_ready  = rnd;
        fixed_ready = val;
        repeat (2) @(posedge clk);
        #1;
    endtask

    // Caller is aligned 1 time unit after a rising edge; returns aligned the same way.
    task automatic send_frame(input int nbeats, input bit reverse, input bit gaps,
                              input bit chk_lat, input bit no_last);
        logic [DATA_W-1:0] fbuf [N];
        logic [DATA_W-1:0] d;
        bit                accepted;
        int                k;
        accepted = (pending < 2);
        for (int i = 0; i < nbeats; i++) begin
            if (gaps && i != 0) begin
                while ($urandom_range(0, 3) == 0) begin
                    in_valid = 1'b0;
                    in_last  = 1'b0;
                    @(posedge clk);
                    #1;
                end
            end
            k = reverse ? (N - 1 - i) : i;
            d = DATA_W'({$urandom(), $urandom(), $urandom()});
            fbuf[k]  = d;
            in_data  = d;
            in_k     = {1'($urandom_range(0, 1)), WIDTH'(k)};
            in_valid = 1'b1;
            in_last  = !no_last && (i == nbeats - 1);
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        if (no_last) return;
        if (accepted && nbeats == N) begin
            for (int a = 0; a < N; a++)
                exp_q.push_back('{data: fbuf[a], user: WIDTH'(a), last: (a == N - 1)});
            pending++;
        end
        @(negedge clk);
        if (!accepted) begin
            exp_ovr++;
            exp_drops++;
            check("err_overrun_pulse", err_overrun, 1);
        end else if (nbeats != N) begin
            exp_len++;
            exp_drops++;
            check("err_len_pulse", err_len, 1);
        end else begin
            check("no_err_good_frame", {err_len, err_overrun}, 0);
        end
        if (chk_lat) begin
            @(negedge clk);
            check("latency_t2_idle", m_tvalid, 0);
            @(negedge clk);
            check("latency_t3_valid", m_tvalid, 1);
            check("latency_first_bin", m_tuser, 0);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic wait_drain();
        int cyc = 0;
        while ((exp_q.size() != 0 || pending != 0) && cyc < 20000) begin
            @(posedge clk);
            cyc++;
        end
        #1;
        if (exp_q.size() != 0 || pending != 0) fail_now("drain_timeout");
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic wait_free();
        int cyc = 0;
        while (pending >= 2 && cyc < 20000) begin
            @(posedge clk);
            cyc++;
        end
        if (pending >= 2) fail_now("free_timeout");
        repeat (3) @(posedge clk);
        #1;
    endtask

    initial begin
        #1_500_000;
        $display("FAIL watchdog: actual still running required finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1; in_data = '0; in_valid = 1'b0; in_last = 1'b0; in_k = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_outputs("reset");
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("in_ready_after_reset", in_ready, 1);
        @(posedge clk); #1;

        // Single natural-order frame with full throughput and latency check
        set_ready(1'b0, 1'b1);
        send_frame(N, 1'b0, 1'b0, 1'b1, 1'b0);
        check("t1_in_ready", in_ready, 1);
        wait_drain();
        check("t1_in_ready_end", in_ready, 1);

        // Three back-to-back frames against a stalled sink
        set_ready(1'b0, 1'b0);
        send_frame(N, 1'b0, 1'b0, 1'b0, 1'b0);
        check("t2_in_ready_one_full", in_ready, 1);
        send_frame(N, 1'b1, 1'b0, 1'b0, 1'b0);
        check("t2_in_ready_both_full", in_ready, 0);
        send_frame(N, 1'b0, 1'b0, 1'b0, 1'b0);
        repeat (2) @(posedge clk); #1;
        check("t2_no_output_while_stalled", exp_q.size(), 2 * N);
`ifdef FEEDER_DROP_CNT_EN
        check("t2_drop_cnt", drop_cnt, 16'(exp_drops));
`endif
        set_ready(1'b0, 1'b1);
        wait_drain();
        check("t2_in_ready_released", in_ready, 1);

        // Randomised sink ready over four frames with input gaps
        set_ready(1'b1, 1'b1);
        for (int f = 0; f < 4; f++) begin
            wait_free();
            send_frame(N, 1'($urandom_range(0, 1)), 1'b1, 1'b0, 1'b0);
        end
        wait_drain();

        // Short frames are discarded
        set_ready(1'b0, 1'b1);
        send_frame(N - 1, 1'b0, 1'b0, 1'b0, 1'b0);
        repeat (2) @(posedge clk); #1;
        check("t4_in_ready_after_short", in_ready, 1);
        send_frame(1, 1'b0, 1'b0, 1'b0, 1'b0);
        repeat (20) @(posedge clk); #1;
        check("t4_no_output", m_tvalid, 0);

        // Reverse write order still comes out in natural order
        send_frame(N, 1'b1, 1'b0, 1'b1, 1'b0);
        wait_drain();

        // Reset in the middle of both writing and reading
        set_ready(1'b1, 1'b1);
        send_frame(N, 1'b0, 1'b0, 1'b0, 1'b0);
        send_frame(1000, 1'b0, 1'b0, 1'b0, 1'b1);
        check("t6_mid_read", m_tvalid, 1);
        rst = 1'b1;
        exp_q.delete();
        pending = 0;
        exp_drops = 0;
        @(posedge clk);
        @(negedge clk);
        check_reset_outputs("mid_reset");
        @(posedge clk); #1;
        rst = 1'b0;
        set_ready(1'b0, 1'b1);
        check("t6_in_ready_after_reset", in_ready, 1);
        send_frame(N, 1'b0, 1'b0, 1'b1, 1'b0);
        wait_drain();

        check("err_len_count", obs_len, exp_len);
        check("err_overrun_count", obs_ovr, exp_ovr);
        check("scoreboard_empty", exp_q.size(), 0);
`ifdef FEEDER_DROP_CNT_EN
        check("final_drop_cnt", drop_cnt, 16'(exp_drops));
`endif
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
